// File: rtl/column_plot_sequencer.sv
// Per-frame column walker: fetches wall height/colour per screen column and issues vertically
// centred rectangle jobs to the plotter. Define COLUMN_CLEAR_BG_EN to also paint ceiling/floor.
module column_plot_sequencer #(
  parameter int unsigned NUM_COLS    = 40,
  parameter int unsigned X_STEP      = 4,
`ifdef COLUMN_CLEAR_BG_EN
  parameter logic [2:0]  CEIL_COLOR  = 3'b001,
  parameter logic [2:0]  FLOOR_COLOR = 3'b010,
`endif
  parameter int unsigned SCREEN_H    = 120
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_start,
  output logic       col_req,
  output logic [5:0] col_index,
  input  logic       col_valid,
  input  logic [6:0] wall_height,
  input  logic [2:0] wall_color,
  output logic       start_plot,
  input  logic       end_plot,
  output logic [7:0] X_pos,
  output logic [6:0] Y_pos,
  output logic [6:0] rect_size,
  output logic [2:0] color,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [6:0] ScreenH = 7'(SCREEN_H);
  localparam logic [5:0] LastCol = 6'(NUM_COLS - 1);

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StCalc,
`ifdef COLUMN_CLEAR_BG_EN
    StCeil,
    StWaitCeil,
`endif
    StWall,
    StWaitWall,
`ifdef COLUMN_CLEAR_BG_EN
    StFloor,
    StWaitFloor,
`endif
    StNext,
    StDone
  } state_e;

  state_e     state_q;
  logic [6:0] height_q;
  logic [2:0] wall_color_q;
  logic [6:0] h_clamp;
  logic [6:0] y_calc;
  logic [7:0] x_calc;

  always_comb begin
    h_clamp = (height_q > ScreenH) ? ScreenH : height_q;
    y_calc  = (ScreenH - h_clamp) >> 1;
    x_calc  = 8'(32'(col_index) * X_STEP);
  end

`ifdef COLUMN_CLEAR_BG_EN
  // Wall geometry is kept so the ceiling and floor can be derived around it.
  logic [6:0] h_q;
  logic [6:0] y_q;
  logic [6:0] floor_y;
  logic [6:0] floor_size;

  always_comb begin
    floor_y    = y_q + h_q;
    floor_size = ScreenH - y_q - h_q;
  end
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      height_q     <= '0;
      wall_color_q <= '0;
`ifdef COLUMN_CLEAR_BG_EN
      h_q          <= '0;
      y_q          <= '0;
`endif
      col_req      <= 1'b0;
      col_index    <= '0;
      start_plot   <= 1'b0;
      X_pos        <= '0;
      Y_pos        <= '0;
      rect_size    <= '0;
      color        <= '0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      start_plot <= 1'b0;
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start) begin
            col_index <= '0;
            busy      <= 1'b1;
            col_req   <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          if (col_valid) begin
            height_q     <= wall_height;
            wall_color_q <= wall_color;
            col_req      <= 1'b0;
            state_q      <= StCalc;
          end
        end
        StCalc: begin
          X_pos <= x_calc;
`ifdef COLUMN_CLEAR_BG_EN
          h_q        <= h_clamp;
          y_q        <= y_calc;
          Y_pos      <= '0;
          rect_size  <= y_calc;
          color      <= CEIL_COLOR;
          start_plot <= (y_calc != '0);
          state_q    <= StCeil;
`else
          Y_pos      <= y_calc;
          rect_size  <= h_clamp;
          color      <= wall_color_q;
          start_plot <= (h_clamp != '0);
          state_q    <= StWall;
`endif
        end
`ifdef COLUMN_CLEAR_BG_EN
        StCeil: begin
          if (rect_size != '0) begin
            state_q <= StWaitCeil;
          end else begin
            Y_pos      <= y_q;
            rect_size  <= h_q;
            color      <= wall_color_q;
            start_plot <= (h_q != '0);
            state_q    <= StWall;
          end
        end
        StWaitCeil: begin
          if (end_plot) begin
            Y_pos      <= y_q;
            rect_size  <= h_q;
            color      <= wall_color_q;
            start_plot <= (h_q != '0);
            state_q    <= StWall;
          end
        end
`endif
        StWall: begin
          if (rect_size != '0) begin
            state_q <= StWaitWall;
          end else begin
`ifdef COLUMN_CLEAR_BG_EN
            Y_pos      <= floor_y;
            rect_size  <= floor_size;
            color      <= FLOOR_COLOR;
            start_plot <= (floor_size != '0);
            state_q    <= StFloor;
`else
            state_q <= StNext;
`endif
          end
        end
        StWaitWall: begin
          if (end_plot) begin
`ifdef COLUMN_CLEAR_BG_EN
            Y_pos      <= floor_y;
            rect_size  <= floor_size;
            color      <= FLOOR_COLOR;
            start_plot <= (floor_size != '0);
            state_q    <= StFloor;
`else
            state_q <= StNext;
`endif
          end
        end
`ifdef COLUMN_CLEAR_BG_EN
        StFloor: begin
          state_q <= (rect_size != '0) ? StWaitFloor : StNext;
        end
        StWaitFloor: begin
          if (end_plot) state_q <= StNext;
        end
`endif
        StNext: begin
          if (col_index == LastCol) begin
            frame_done <= 1'b1;
            state_q    <= StDone;
          end else begin
            col_index <= col_index + 6'd1;
            col_req   <= 1'b1;
            state_q   <= StReq;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_column_plot_sequencer.sv
// Self-checking bench for column_plot_sequencer: acts as raycaster and plotter, compares every
// rectangle job against a per-column geometry model. Honours COLUMN_CLEAR_BG_EN.
module tb_column_plot_sequencer;

  localparam int NumCols = 40;
  localparam int ScreenH = 120;

  logic       clock       = 1'b0;
  logic       resetn      = 1'b0;
  logic       frame_start = 1'b0;
  logic       col_valid   = 1'b0;
  logic       end_plot    = 1'b0;
  logic [6:0] wall_height = '0;
  logic [2:0] wall_color  = '0;
  logic       col_req, start_plot, busy, frame_done;
  logic [5:0] col_index;
  logic [7:0] X_pos;
  logic [6:0] Y_pos, rect_size;
  logic [2:0] color;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hts[NumCols];
  int clr[NumCols];

  typedef struct {
    int x;
    int y;
    int size;
    int color;
  } plot_t;

  plot_t exp_q[$];

  column_plot_sequencer dut (
    .clock       (clock),
    .resetn      (resetn),
    .frame_start (frame_start),
    .col_req     (col_req),
    .col_index   (col_index),
    .col_valid   (col_valid),
    .wall_height (wall_height),
    .wall_color  (wall_color),
    .start_plot  (start_plot),
    .end_plot    (end_plot),
    .X_pos       (X_pos),
    .Y_pos       (Y_pos),
    .rect_size   (rect_size),
    .color       (color),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected rectangle list for a whole frame, in plot order.
  task automatic model_frame();
    exp_q.delete();
    for (int c = 0; c < NumCols; c++) begin
      int h;
      int y;
      int x;
      h = (hts[c] > ScreenH) ? ScreenH : hts[c];
      y = (ScreenH - h) / 2;
      x = c * 4;
`ifdef COLUMN_CLEAR_BG_EN
      if (y > 0) exp_q.push_back('{x, 0, y, 1});
`endif
      if (h > 0) exp_q.push_back('{x, y, h, clr[c]});
`ifdef COLUMN_CLEAR_BG_EN
      if (ScreenH - y - h > 0) exp_q.push_back('{x, y + h, ScreenH - y - h, 2});
`endif
    end
  endtask

  task automatic randomize_columns();
    for (int c = 0; c < NumCols; c++) begin
      hts[c] = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(127, 0));
      clr[c] = int'($urandom_range(7, 0));
    end
  endtask

  // Called at a negedge; serves one full frame and checks every job.
  task automatic run_frame(input int vmin, input int vmax, input int emin, input int emax,
                           input bit poke);
    plot_t p;
    int    col;
    int    wcount;
    int    vtarget;
    int    guard;
    int    valid_cyc;
    int    ed;
    bit    done;
    bit    lat_pending;
    col         = 0;
    wcount      = 0;
    guard       = 0;
    valid_cyc   = 0;
    done        = 1'b0;
    lat_pending = 1'b0;
    model_frame();
    vtarget = int'($urandom_range(vmax, vmin));
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    check("busy_on_accept", busy, 1);
    while (!done && guard < 20000) begin
      guard++;
      if (frame_done) begin
        check("done_col_index", col_index, NumCols - 1);
        check("done_cols_served", col, NumCols);
        check("done_no_missing_plots", exp_q.size(), 0);
        check("done_busy_still_high", busy, 1);
        done = 1'b1;
      end else if (col_req) begin
        if (col >= NumCols) begin
          check("col_req_past_last", col_index, NumCols - 1);
        end else if (wcount >= vtarget) begin
          check("req_col_index", col_index, col);
          col_valid   = 1'b1;
          wall_height = 7'(hts[col]);
          wall_color  = 3'(clr[col]);
          valid_cyc   = cyc;
          lat_pending = 1'b1;
          col++;
          wcount  = 0;
          vtarget = int'($urandom_range(vmax, vmin));
        end else begin
          wcount++;
        end
      end
      if (start_plot) begin
        check("plot_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
`ifndef COLUMN_CLEAR_BG_EN
          if (lat_pending) check("valid_to_start_latency", cyc - valid_cyc, 2);
`endif
          lat_pending = 1'b0;
          check("x_pos", X_pos, p.x);
          check("y_pos", Y_pos, p.y);
          check("rect_size", rect_size, p.size);
          check("color", color, p.color);
          ed = int'($urandom_range(emax, emin));
          for (int i = 0; i < ed; i++) begin
            @(negedge clock);
            col_valid   = 1'b0;
            frame_start = poke && (i == ed / 2);
            check("start_plot_one_cycle", start_plot, 0);
            check("hold_job", {X_pos, Y_pos, rect_size, color},
                  {8'(p.x), 7'(p.y), 7'(p.size), 3'(p.color)});
          end
          end_plot = 1'b1;
        end
      end
      @(negedge clock);
      col_valid   = 1'b0;
      end_plot    = 1'b0;
      frame_start = 1'b0;
    end
    check("frame_completed_in_budget", done, 1);
    check("busy_after_done", {busy, frame_done}, 0);
  endtask

  initial begin
    int guard;
    #1;
    check("reset_ctrl", {col_req, col_index, start_plot, busy, frame_done}, 0);
    check("reset_job", {X_pos, Y_pos, rect_size, color}, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_after_reset", {col_req, busy, start_plot}, 0);

    // Reset while a wall job is outstanding.
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
    guard = 0;
    while (!col_req && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("abort_req_seen", col_req, 1);
    col_valid   = 1'b1;
    wall_height = 7'd40;
    wall_color  = 3'd5;
    @(negedge clock);
    col_valid = 1'b0;
    guard = 0;
    while (!start_plot && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("abort_start_seen", start_plot, 1);
    @(negedge clock);
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check("abort_ctrl_zero", {col_req, col_index, start_plot, busy, frame_done}, 0);
    check("abort_job_zero", {X_pos, Y_pos, rect_size, color}, 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      end_plot  = (i == 2);
      col_valid = (i == 4);
      @(negedge clock);
      check("abort_quiet", {start_plot, busy, col_req, frame_done}, 0);
    end
    end_plot  = 1'b0;
    col_valid = 1'b0;

    // Uniform walls: every column h=40, colour 5.
    for (int c = 0; c < NumCols; c++) begin
      hts[c] = 40;
      clr[c] = 5;
    end
    run_frame(0, 0, 1, 1, 1'b0);

    // Clamp, odd height, zero-height skip.
    randomize_columns();
    hts[0] = 127;
    hts[1] = 7;
    hts[3] = 0;
    hts[5] = 120;
    hts[6] = 20;
    run_frame(0, 3, 1, 4, 1'b0);

    // Slow raycaster and plotter, frame_start pokes while busy.
    randomize_columns();
    run_frame(10, 10, 50, 50, 1'b1);

    repeat (2) begin
      randomize_columns();
      run_frame(0, 2, 1, 3, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
